// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM encoding and iteration count for the
// multiply/divide sequencer.
package mdu_pkg;
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;
  localparam int ITER = 32;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
endpackage

// File: rtl/mdu_seq_step.sv
// mdu_step: one radix-2 iteration, shift-add multiply or restoring divide
// on unsigned magnitudes.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] prt_i,
  input  logic [WIDTH-1:0] opd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] prt_o
);
  logic [WIDTH:0] add, shl, diff, rem;
  logic ge;
  always_comb begin
    add   = prt_i[0] ? {1'b0, acc_i} + {1'b0, opd_i} : {1'b0, acc_i};
    shl   = {acc_i, prt_i[WIDTH-1]};
    diff  = shl - {1'b0, opd_i};
    // a set top bit in shl already exceeds any divisor; otherwise the borrow decides
    ge    = shl[WIDTH] | ~diff[WIDTH];
    rem   = ge ? diff : shl;
    acc_o = div_i ? rem[WIDTH-1:0] : add[WIDTH:1];
    prt_o = div_i ? {prt_i[WIDTH-2:0], ge} : {add[0], prt_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers;
// 32 magnitude iterations followed by one sign-correction cycle.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic div_q, div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic done_q, done_d, divzero_q, divzero_d;
  logic [WIDTH-1:0] a_q, a_d, opd_q, opd_d, acc_q, acc_d, prt_q, prt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] acc_n, prt_n, mag_a, mag_b, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic sgn, op_div;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_i(div_q),
    .acc_i(acc_q),
    .prt_i(prt_q),
    .opd_i(opd_q),
    .acc_o(acc_n),
    .prt_o(prt_n)
  );

  always_comb begin
    sgn       = (op == MDU_MULT) || (op == MDU_DIV);
    op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    mag_a     = (sgn && dataa[WIDTH-1]) ? -dataa : dataa;
    mag_b     = (sgn && datab[WIDTH-1]) ? -datab : datab;
    prod      = (sa_q ^ sb_q) ? -{acc_q, prt_q} : {acc_q, prt_q};
    quo       = (sa_q ^ sb_q) ? -prt_q : prt_q;
    rem       = sa_q ? -acc_q : acc_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    dz_d      = dz_q;
    a_d       = a_q;
    opd_d     = opd_q;
    acc_d     = acc_q;
    prt_d     = prt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          state_d = CALC;
          cnt_d   = '0;
          div_d   = op_div;
          sa_d    = sgn & dataa[WIDTH-1];
          sb_d    = sgn & datab[WIDTH-1];
          dz_d    = op_div && (datab == '0);
          a_d     = dataa;
          opd_d   = op_div ? mag_b : mag_a;
          prt_d   = op_div ? mag_a : mag_b;
          acc_d   = '0;
        end else if (!start) begin
          hi_d = hi_we ? wdata : hi_q;
          lo_d = lo_we ? wdata : lo_q;
        end
      end
      CALC: begin
        state_d = cancel ? IDLE : (cnt_q == CNT_W'(ITER - 1)) ? FIX : CALC;
        cnt_d   = cancel ? '0 : cnt_q + 1'b1;
        acc_d   = acc_n;
        prt_d   = prt_n;
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          // divide by zero returns all-ones quotient and the untouched dividend
          hi_d      = div_q ? (dz_q ? a_q : rem) : prod[2*WIDTH-1:WIDTH];
          lo_d      = div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
          divzero_d = dz_q;
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      dz_q      <= 1'b0;
      a_q       <= '0;
      opd_q     <= '0;
      acc_q     <= '0;
      prt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      dz_q      <= dz_d;
      a_q       <= a_d;
      opd_q     <= opd_d;
      acc_q     <= acc_d;
      prt_q     <= prt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer that provides ALU unit 11 (MULT, MULTU, DIV, DIVU) and owns the architectural HI/LO registers.
- Sits beside the ALU in EX. The pipeline issues an operation with a start pulse and stalls on busy. Results are read from HI/LO, and the pipeline writes them directly for MTHI/MTLO.
- Uses a radix-2 algorithm with one result bit per cycle: shift-add multiply and restoring divide on operand magnitudes, followed by a final sign-correction cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clrn  input  1  asynchronous active-low reset.
- start  input  1  launch the operation selected by op; sampled only in IDLE.
- op  input  2  function code, equal to alufunc[1:0] of unit 11: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- dataa  input  WIDTH  multiplicand or dividend (rs).
- datab  input  WIDTH  multiplier or divisor (rt).
- cancel  input  1  pipeline flush; aborts the operation in flight.
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO write data.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- divzero  output  1  sticky flag: the last completed DIV/DIVU had datab==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: clrn=0 asynchronously forces state=IDLE, hi=0, lo=0, busy=0, done=0, divzero=0, counter=0. This holds even mid-operation; no partial result survives.
- States:
  - IDLE: start=1 captures op, the operand signs, |dataa| and |datab| (magnitudes only for signed ops, raw values for unsigned), and clears the accumulator. The block then goes to CALC with counter=0 and busy=1.
  - CALC: one iteration per cycle. The counter increments and wraps from 31 to 0; the cycle at counter=31 moves to FIX.
  - FIX: applies sign correction and writes HI/LO, asserts done for the following cycle, drops busy and returns to IDLE.
- Latency:
  - start sampled at edge 0; HI/LO updated, done=1 and busy=0 after edge 33. This is fixed for all ops and operands, including divide by zero.
  - busy is high from edge 0 through edge 33.
  - A new start is accepted in the cycle done is high, so back-to-back issue is possible.
- Multiply:
  - 64-bit product with HI = [63:32] and LO = [31:0].
  - MULT negates the 64-bit product if the operand signs differ.
- Divide:
  - LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
  - Signed result: quotient negated if the signs differ; remainder negated if the dividend is negative.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 with no trap.
- Divide by zero (datab==0 on DIV/DIVU):
  - FIX writes LO=0xFFFFFFFF and HI=dataa as captured.
  - divzero is set at FIX.
  - divzero is cleared at the FIX of any subsequent op that is not a divide by zero, including multiplies.
- cancel:
  - In CALC or FIX it returns to IDLE on the next edge with busy=0. done is not pulsed and HI/LO/divzero are unchanged.
  - cancel in IDLE has no effect, and cancel has priority over start in the same cycle.
- start while busy is ignored; no queueing.
- hi_we/lo_we:
  - Take effect only in IDLE with start=0; otherwise they are dropped.
  - Both may be asserted in the same cycle.
  - A write does not change divzero.
- done is never asserted outside the cycle after FIX.
- Arithmetic: all internal adders and subtractors are WIDTH+1 bits wide. Operand magnitudes are held as WIDTH-bit unsigned, so |0x80000000| = 0x80000000 is exact.

Decomposition:
- Shared package holds:
  - op code constants MDU_MULT, MDU_MULTU, MDU_DIV and MDU_DIVU (matching the ALU 11xx codes);
  - state encoding IDLE/CALC/FIX;
  - ITER=32.
- One natural sub-module, mdu_step: purely combinational single iteration.
  - Inputs: mode (mul/div), accumulator, partial register, operand.
  - Outputs: next accumulator and partial register.
- mdu_seq keeps the FSM, counter, sign logic and HI/LO.

Test Plan:
1. MULT dataa=0xFFFFFFFE, datab=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; done one cycle only, 33 edges after start; busy high throughout.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Issue DIVU 100/7 in the done cycle -> LO=14, HI=2 after a further 33 edges.
3. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, divzero=0.
4. DIVU 100/0 -> LO=0xFFFFFFFF, HI=100, divzero=1. A following MULT 2x3 -> LO=6, HI=0, divzero=0.
5. MULT 5x5 with cancel at edge 10 -> busy=0 after edge 11, no done, HI/LO keep their previous values. A start at edge 5 of a running op is ignored.
6. lo_we=1, wdata=0x1234 in IDLE -> LO=0x1234. Repeat with start=1 in the same cycle, or during busy -> write dropped. clrn pulsed low mid-CALC -> all outputs 0 immediately.
